// File: rtl/ysyx_24070016_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// response codes, reset/fault defaults and datapath widths.
package ysyx_24070016_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    // Fetch FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

    localparam logic [1:0]        RESP_OKAY    = 2'b00;
    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0013;

    // A fetch address is usable only when word aligned
    function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_24070016_ifu_pcgen.sv
// PC register and next-PC selection. A redirect always wins; otherwise the
// PC steps by 4 (wrapping modulo 2^32) when the held instruction is consumed.
module ysyx_24070016_ifu_pcgen
    import ysyx_24070016_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              pc_aligned_o,
    output logic              next_aligned_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next-PC mux: redirect, sequential step, or hold
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o           = pc_q;
    assign next_pc_o      = pc_d;
    assign pc_aligned_o   = is_aligned(pc_q);
    assign next_aligned_o = is_aligned(pc_d);

endmodule

// File: rtl/ysyx_24070016_ifu.sv
// Instruction fetch unit: one outstanding single-beat read to instruction
// memory, one-entry holding register toward the decoder, redirect and
// sticky-halt handling. All outward signals are registered.
module ysyx_24070016_ifu
    import ysyx_24070016_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [INST_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              ifu_halt
);

    ifu_state_e        state_q;
    logic              drop_q;
    logic              halted_q;
    logic [ADDR_W-1:0] araddr_q;
    logic              arvalid_q;
    logic              rready_q;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic              inst_fault_q;
    logic              inst_valid_q;

    logic [ADDR_W-1:0] pc_s;
    logic [ADDR_W-1:0] next_pc_s;
    logic              pc_aligned_s;
    logic              next_aligned_s;
    logic              halt_now_s;
    logic              hold_hs_s;

    // Halt takes effect in the very cycle it is first seen
    assign halt_now_s = halted_q | ifu_halt;
    assign hold_hs_s  = (state_q == HOLD) & inst_valid_q & inst_ready;

    ysyx_24070016_ifu_pcgen #(
        .RESET_PC (RESET_PC)
    ) u_pcgen (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_i     (redirect_valid),
        .redirect_pc_i  (redirect_pc),
        .advance_i      (hold_hs_s),
        .pc_o           (pc_s),
        .next_pc_o      (next_pc_s),
        .pc_aligned_o   (pc_aligned_s),
        .next_aligned_o (next_aligned_s)
    );

    // Fetch FSM with registered bus and decoder-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            drop_q       <= 1'b0;
            halted_q     <= 1'b0;
            araddr_q     <= RESET_PC;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_q       <= {INST_W{1'b0}};
            inst_pc_q    <= RESET_PC;
            inst_fault_q <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            if (ifu_halt) begin
                halted_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    // A redirect here only moves the PC; the fetch starts
                    // next cycle from the new value.
                    if (halt_now_s || redirect_valid) begin
                        state_q <= IDLE;
                    end else if (!pc_aligned_s) begin
                        state_q      <= HOLD;
                        inst_q       <= NOP_INST;
                        inst_pc_q    <= pc_s;
                        inst_fault_q <= 1'b1;
                        inst_valid_q <= 1'b1;
                    end else begin
                        state_q   <= REQ;
                        arvalid_q <= 1'b1;
                        araddr_q  <= pc_s;
                    end
                end
                REQ: begin
                    // The request cannot be withdrawn; a redirect marks the
                    // coming response as stale instead.
                    if (redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        drop_q   <= 1'b0;
                        if (drop_q || redirect_valid || halt_now_s) begin
                            state_q <= IDLE;
                        end else begin
                            inst_q       <= rdata;
                            inst_pc_q    <= pc_s;
                            inst_fault_q <= (rresp != RESP_OKAY);
                            inst_valid_q <= 1'b1;
                            state_q      <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        inst_valid_q <= 1'b0;
                        if (!halt_now_s && next_aligned_s) begin
                            state_q   <= REQ;
                            arvalid_q <= 1'b1;
                            araddr_q  <= next_pc_s;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (redirect_valid || halt_now_s) begin
                        inst_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    arvalid_q    <= 1'b0;
                    rready_q     <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign araddr     = araddr_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = inst_fault_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_ysyx_24070016_ifu.sv
// Bench for the fetch unit: a small instruction memory responder, a stimulus
// process and a monitor that checks address and instruction handshakes
// against queues of expected values.
module tb_ysyx_24070016_ifu;

    logic        clk;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifu_halt;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t        inst_q[$];
    logic [31:0] addr_q[$];

    int n_cmp = 0;
    int n_mis = 0;
    int ar_delay = 0;
    int r_delay = 0;
    logic expect_quiet = 1'b0;

    ysyx_24070016_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifu_halt       (ifu_halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s", name);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0010_0093;
            32'h8000_0004: return 32'h0020_0113;
            32'h8000_0008: return 32'hDEAD_BEEF;
            32'h8000_0100: return 32'h0030_0193;
            32'h8000_0104: return 32'hBADC_0DE5;
            32'h8000_0108: return 32'h0040_0213;
            default:       return ~a;
        endcase
    endfunction

    function automatic logic [1:0] mem_resp(input logic [31:0] a);
        return (a == 32'h8000_0104) ? 2'b10 : 2'b00;
    endfunction

    // Memory responder: drives arready/rvalid just after each rising edge
    initial begin : memory
        logic        a_fire;
        logic        r_fire;
        logic        r_pend;
        logic        ar_busy;
        int          ar_cnt;
        int          r_cnt;
        logic [31:0] a_addr;
        logic [31:0] r_addr;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        a_fire = 1'b0; r_fire = 1'b0; r_pend = 1'b0; ar_busy = 1'b0;
        ar_cnt = 0; r_cnt = 0; a_addr = 32'h0; r_addr = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                arready = 1'b0; rvalid = 1'b0;
                a_fire = 1'b0; r_fire = 1'b0; r_pend = 1'b0; ar_busy = 1'b0;
            end else begin
                if (r_fire) rvalid = 1'b0;
                if (a_fire) begin
                    r_pend = 1'b1; r_cnt = r_delay; r_addr = a_addr;
                end
                if (r_pend && !rvalid) begin
                    if (r_cnt == 0) begin
                        rvalid = 1'b1; rdata = mem_word(r_addr); rresp = mem_resp(r_addr); r_pend = 1'b0;
                    end else begin
                        r_cnt--;
                    end
                end
                if (arvalid) begin
                    if (!ar_busy) begin
                        ar_busy = 1'b1; ar_cnt = ar_delay;
                    end
                    arready = (ar_cnt == 0);
                    if (ar_cnt != 0) ar_cnt--;
                end else begin
                    arready = 1'b0;
                end
                a_fire = arvalid && arready;
                a_addr = araddr;
                if (a_fire) ar_busy = 1'b0;
                r_fire = rvalid && rready;
            end
        end
    end

    // Monitor: compares handshakes against the expected queues on falling edges
    initial begin : monitor
        logic        p_arv, p_arr, p_iv, p_ir, p_flt;
        logic [31:0] p_ara, p_inst, p_ipc;
        exp_t        e;
        p_arv = 1'b0; p_arr = 1'b0; p_iv = 1'b0; p_ir = 1'b0; p_flt = 1'b0;
        p_ara = 32'h0; p_inst = 32'h0; p_ipc = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (arvalid && arready) begin
                    if (addr_q.size() == 0) begin
                        fail_now($sformatf("ar_unexpected: request at %08h with none expected", araddr));
                    end else begin
                        check("araddr", araddr, addr_q.pop_front());
                    end
                end
                if (p_arv && !p_arr) begin
                    check("ar_hold_valid", {31'b0, arvalid}, 32'd1);
                    check("ar_hold_addr", araddr, p_ara);
                end
                if (inst_valid && inst_ready) begin
                    if (inst_q.size() == 0) begin
                        fail_now($sformatf("inst_unexpected: inst %08h pc %08h with none expected", inst, inst_pc));
                    end else begin
                        e = inst_q.pop_front();
                        check("inst", inst, e.word);
                        check("inst_pc", inst_pc, e.pc);
                        check("inst_fault", {31'b0, inst_fault}, {31'b0, e.fault});
                    end
                end
                if (p_iv && !p_ir) begin
                    check("hold_valid", {31'b0, inst_valid}, 32'd1);
                    check("hold_inst", inst, p_inst);
                    check("hold_pc", inst_pc, p_ipc);
                    check("hold_fault", {31'b0, inst_fault}, {31'b0, p_flt});
                end
                if (expect_quiet) begin
                    check("quiet_arvalid", {31'b0, arvalid}, 32'd0);
                    check("quiet_inst_valid", {31'b0, inst_valid}, 32'd0);
                    check("quiet_rready", {31'b0, rready}, 32'd0);
                end
                p_arv = arvalid; p_arr = arready; p_ara = araddr;
                p_iv = inst_valid; p_ir = inst_ready; p_inst = inst; p_ipc = inst_pc; p_flt = inst_fault;
            end else begin
                p_arv = 1'b0; p_iv = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_arvalid"}, {31'b0, arvalid}, 32'd0);
        check({tag, "_rready"}, {31'b0, rready}, 32'd0);
        check({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'd0);
        check({tag, "_inst"}, inst, 32'h0000_0000);
        check({tag, "_inst_pc"}, inst_pc, 32'h8000_0000);
        check({tag, "_inst_fault"}, {31'b0, inst_fault}, 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !inst_valid; i++) step();
        if (!inst_valid) fail_now({tag, "_timeout waiting for inst_valid"});
    endtask

    // Consume the presented instruction, optionally redirecting in the same cycle
    task automatic accept(input logic redir, input logic [31:0] rpc);
        wait_valid("accept");
        inst_ready = 1'b1;
        redirect_valid = redir;
        redirect_pc = rpc;
        step();
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
    endtask

    function automatic exp_t mk(input logic [31:0] w, input logic [31:0] p, input logic f);
        exp_t e;
        e.word = w; e.pc = p; e.fault = f;
        return e;
    endfunction

    initial begin : stimulus
        rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; ifu_halt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");

        // First fetch and its latency
        addr_q.push_back(32'h8000_0000);
        inst_q.push_back(mk(32'h0010_0093, 32'h8000_0000, 1'b0));
        addr_q.push_back(32'h8000_0004);
        rst_n = 1'b1;
        step();
        check("c1_arvalid", {31'b0, arvalid}, 32'd1);
        check("c1_araddr", araddr, 32'h8000_0000);
        step();
        step();
        check("c3_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("c3_inst", inst, 32'h0010_0093);
        check("c3_inst_pc", inst_pc, 32'h8000_0000);
        accept(1'b0, 32'h0);

        // Decoder stalls for 5 cycles
        inst_q.push_back(mk(32'h0020_0113, 32'h8000_0004, 1'b0));
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_no_arvalid", {31'b0, arvalid}, 32'd0);
        end
        addr_q.push_back(32'h8000_0008);
        r_delay = 2;
        accept(1'b0, 32'h0);

        // Redirect while waiting for data; the stale word must never appear
        addr_q.push_back(32'h8000_0100);
        inst_q.push_back(mk(32'h0030_0193, 32'h8000_0100, 1'b0));
        for (int i = 0; i < 20 && !rready; i++) step();
        if (!rready) fail_now("redir_timeout waiting for rready");
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        r_delay = 0;
        addr_q.push_back(32'h8000_0104);
        inst_q.push_back(mk(32'hBADC_0DE5, 32'h8000_0104, 1'b1));
        addr_q.push_back(32'h8000_0108);
        inst_q.push_back(mk(32'h0040_0213, 32'h8000_0108, 1'b0));
        accept(1'b0, 32'h0);

        // Error response, then the sequential fetch
        accept(1'b0, 32'h0);

        // Redirect to a misaligned target during a handshake
        inst_q.push_back(mk(32'h0000_0013, 32'h8000_0102, 1'b1));
        addr_q.push_back(32'h8000_0200);
        inst_q.push_back(mk(32'h7FFF_FDFF, 32'h8000_0200, 1'b0));
        addr_q.push_back(32'h8000_0204);
        accept(1'b1, 32'h8000_0102);
        ar_delay = 2;
        accept(1'b1, 32'h8000_0200);

        // Halt during a request whose address phase is delayed
        accept(1'b0, 32'h0);
        check("halt_req_arvalid", {31'b0, arvalid}, 32'd1);
        check("halt_req_araddr", araddr, 32'h8000_0204);
        ifu_halt = 1'b1;
        step();
        ifu_halt = 1'b0;
        repeat (10) step();
        ar_delay = 0;
        check("halt_resp_consumed", {31'b0, rvalid}, 32'd0);
        expect_quiet = 1'b1;
        repeat (15) step();
        expect_quiet = 1'b0;

        // Reset clears the halt and fetching resumes at the reset PC
        rst_n = 1'b0;
        #1;
        check_reset("rst2");
        step();
        addr_q.push_back(32'h8000_0000);
        inst_q.push_back(mk(32'h0010_0093, 32'h8000_0000, 1'b0));
        addr_q.push_back(32'h8000_0004);
        rst_n = 1'b1;
        accept(1'b0, 32'h0);
        repeat (5) step();
        check("addr_queue_drained", addr_q.size(), 32'd0);
        check("inst_queue_drained", inst_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ysyx_24070016_ifu.md
Name: ysyx_24070016_ifu

Overview:
Instruction fetch unit, the producer side of the decode interface: owns the PC, issues single-beat AXI4-Lite-style read requests to instruction memory, and presents one fetched word at a time to the IDU over a valid/ready handshake. Accepts PC redirects from execute and a sticky halt (ebreak) from decode. It has one outstanding request at most and a one-entry instruction holding register.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset; first fetch address.
NOP_INST, 32'h0000_0013, word presented on a misaligned-PC fault (addi x0,x0,0).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
araddr  out  32  fetch address; equals the current PC while arvalid is high.
arvalid  out  1  read request valid.
arready  in  1  memory accepts the request.
rdata  in  32  instruction word.
rresp  in  2  response code; 2'b00 means OKAY, any other value means error.
rvalid  in  1  read data valid.
rready  out  1  IFU accepts read data; high only in WAIT.
inst  out  32  instruction to the IDU.
inst_pc  out  32  PC of inst.
inst_fault  out  1  inst is invalid because of a bus error or misalignment.
inst_valid  out  1  inst, inst_pc and inst_fault are valid.
inst_ready  in  1  IDU consumes the instruction.
redirect_valid  in  1  execute requests a PC change.
redirect_pc  in  32  new PC.
ifu_halt  in  1  ebreak seen; stop fetching. Sticky internally until reset.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, state=IDLE, drop=0, halted=0.
  - arvalid=0, rready=0, inst_valid=0, inst=0, inst_pc=RESET_PC, inst_fault=0.
- FSM states are IDLE, REQ, WAIT and HOLD.
  - IDLE: if halted or ifu_halt, stay in IDLE. Else if pc[1:0]!=0, go to HOLD with inst=NOP_INST, inst_fault=1, inst_pc=pc, and no bus request. Else go to REQ.
  - REQ: arvalid=1, araddr=pc. araddr stays stable and arvalid is never retracted until arready. When arvalid&arready, go to WAIT.
  - WAIT: rready=1. When rvalid is seen:
    - If drop=1 or halted, discard the data, clear drop, and go to IDLE.
    - Otherwise latch inst=rdata, inst_pc=pc, inst_fault=(rresp!=0), and go to HOLD.
  - HOLD: inst_valid=1 and the outputs stay stable until inst_ready. On handshake (inst_valid&inst_ready):
    - pc <= redirect_valid ? redirect_pc : pc+4.
    - If not halted, not ifu_halt, and the next pc is aligned, go directly to REQ. Otherwise go to IDLE.
- Latency with a zero-wait memory (arready and rvalid high the cycle after request):
  - Request cycle, then data cycle, then inst_valid on the third cycle.
  - Steady-state throughput is 1 instruction per 3 cycles when the IDU is always ready.
- PC arithmetic: 32-bit, pc+4 wraps modulo 2^32 (32'hFFFF_FFFC goes to 0) with no flag.
- Redirect outside a HOLD handshake:
  - IDLE: pc <= redirect_pc.
  - REQ or WAIT: pc <= redirect_pc and drop <= 1. The in-flight response is discarded and a new fetch starts from IDLE.
  - HOLD without inst_ready: the held instruction is flushed (inst_valid=0 the next cycle), pc <= redirect_pc, go to IDLE.
  - Redirect in the same cycle as the HOLD handshake: the handshake completes and redirect_pc is the next pc.
- Redirect in the same cycle as a WAIT response: drop takes effect, the response is discarded and the new pc is kept.
- ifu_halt:
  - Sets halted on the cycle it is sampled.
  - No new arvalid after that.
  - A request already in REQ completes its address handshake, and its response is consumed and discarded.
  - A HOLD in progress is flushed.
  - Once idle, outputs stay at inst_valid=0, arvalid=0 until reset.
- A reset assertion mid-transaction returns to the reset state immediately. The memory side is reset by the same rst_n.
- rvalid outside WAIT is ignored (rready=0).

Decomposition:
- Shared package ysyx_24070016_pkg holds:
  - the FSM state encoding (2-bit localparams IDLE/REQ/WAIT/HOLD);
  - RESP_OKAY=2'b00;
  - the NOP_INST and RESET_PC defaults;
  - the ADDR_W=32 and INST_W=32 constants.
- One sub-module, ysyx_24070016_ifu_pcgen: holds the PC register and the next-PC mux (redirect, pc+4, hold), with the alignment check output. The FSM and holding register stay in the top module.

Test Plan:
- Reset release, zero-wait memory returning 32'h00100093 at 0x80000000 with inst_ready=1 -> arvalid on cycle 1 with araddr=0x80000000; inst_valid on cycle 3 with inst=0x00100093, inst_pc=0x80000000; next araddr=0x80000004.
- inst_ready held low for 5 cycles in HOLD -> inst and inst_pc stable, arvalid=0 throughout; on ready the next fetch is at pc+4.
- redirect_valid with redirect_pc=0x80000100 while in WAIT, and memory returns 0xDEADBEEF -> 0xDEADBEEF is never presented; the next araddr is 0x80000100.
- redirect_pc=0x80000102 -> no arvalid; inst_valid with inst=0x00000013, inst_fault=1, inst_pc=0x80000102.
- rresp=2'b10 on a fetch -> inst_fault=1 with inst_pc equal to the request address; after the handshake the next fetch is at pc+4.
- ifu_halt pulsed during REQ with arready delayed 2 cycles -> arvalid held until arready; the response is consumed and dropped; afterwards arvalid=0 and inst_valid=0 indefinitely until rst_n pulses low.
